// File: rtl/spi_regfile_periph_if.sv
// SPI pins plus register-file status outputs of the SPI register peripheral.
// The controller side uses master, the peripheral uses slave.
interface spi_regfile_periph_if #(
   parameter int unsigned NUM_REGS = 5,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 7
) ();
   logic                       SCLK;
   logic                       nCS;
   logic                       COPI;
   logic                       CIPO;
   logic                       cipo_oe;
   logic [NUM_REGS*DATA_W-1:0] regs_out;
   logic                       wr_strobe;
   logic [ADDR_W-1:0]          wr_addr;
   logic                       frame_err;

   modport master (
      output SCLK, nCS, COPI,
      input  CIPO, cipo_oe, regs_out, wr_strobe, wr_addr, frame_err
   );

   modport slave (
      input  SCLK, nCS, COPI,
      output CIPO, cipo_oe, regs_out, wr_strobe, wr_addr, frame_err
   );
endinterface

// File: rtl/spi_regfile_periph.sv
// SPI register-file peripheral: oversampled SPI modes 0-3 with register writes,
// readback on CIPO and frame-length checking, all in the clk domain.
module spi_regfile_periph #(
   parameter int unsigned NUM_REGS = 5,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 7,
   parameter int unsigned CPOL     = 0,
   parameter int unsigned CPHA     = 0
) (
   input  logic                clk,
   input  logic                rst,
   spi_regfile_periph_if.slave bus
);
   localparam int unsigned FRAME  = 1 + ADDR_W + DATA_W;
   localparam int unsigned CNT_W  = $clog2(FRAME + 2);
   localparam int unsigned REGS_W = NUM_REGS * DATA_W;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [2:0]        sclk_sync_q, sclk_sync_d;
   logic [2:0]        ncs_sync_q, ncs_sync_d;
   logic [1:0]        copi_sync_q, copi_sync_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FRAME-1:0]  rx_q, rx_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              cipo_q, cipo_d;
   logic              cipo_oe_q, cipo_oe_d;
   logic [REGS_W-1:0] regs_q, regs_d;
   logic              wr_strobe_q, wr_strobe_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              frame_err_q, frame_err_d;

   logic              sclk_rise, sclk_fall, lead_edge, trail_edge;
   logic              sample_edge, shift_edge;
   logic              ncs_s, ncs_rise, ncs_fall, copi_s;
   logic [FRAME-1:0]  frame_in;
   logic [DATA_W-1:0] rd_word;

   // Synchronisers and edge classification; [2] is the one-cycle-delayed copy.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], bus.SCLK};
      ncs_sync_d  = {ncs_sync_q[1:0], bus.nCS};
      copi_sync_d = {copi_sync_q[0], bus.COPI};
      sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
      sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
      lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
      trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
      sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
      shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
      ncs_s       = ncs_sync_q[1];
      ncs_rise    = ncs_sync_q[1] & ~ncs_sync_q[2];
      ncs_fall    = ~ncs_sync_q[1] & ncs_sync_q[2];
      copi_s      = copi_sync_q[1];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_d        = rx_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      tx_d        = tx_q;
      cipo_d      = cipo_q;
      cipo_oe_d   = 1'b0;
      regs_d      = regs_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      frame_err_d = 1'b0;
      frame_in    = {rx_q[FRAME-2:0], copi_s};
      rd_word     = '0;

      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (frame_in[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
      end

      // Counting is gated by state so a frame already in progress at reset release is ignored.
      if (ncs_s) begin
         cnt_d = '0;
      end else if (state_q != S_IDLE && sample_edge) begin
         if (cnt_q < CNT_W'(FRAME + 1)) cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q < CNT_W'(FRAME))     rx_d  = frame_in;
      end

      unique case (state_q)
         S_IDLE: begin
            if (ncs_fall) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (!ncs_s && sample_edge && cnt_q == CNT_W'(ADDR_W)) begin
               state_d = S_DATA;
               rw_d    = frame_in[ADDR_W];
               addr_d  = frame_in[ADDR_W-1:0];
               tx_d    = '0;
               if (!frame_in[ADDR_W]) begin
                  // CPHA=0 must present the MSB before the first data sample edge.
                  if (CPHA == 0) begin
                     cipo_d = rd_word[DATA_W-1];
                     tx_d   = {rd_word[DATA_W-2:0], 1'b0};
                  end else begin
                     tx_d   = rd_word;
                  end
               end
            end
         end
         S_DATA: begin
            if (sample_edge && cnt_q == CNT_W'(FRAME - 1)) state_d = S_DONE;
            // With CPHA=0 the shift edge closing the last address bit must not advance data.
            if (shift_edge && !rw_q && (CPHA != 0 || cnt_q > CNT_W'(ADDR_W + 1))) begin
               cipo_d = tx_q[DATA_W-1];
               tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
         end
         S_DONE: begin
         end
         default: state_d = S_IDLE;
      endcase

      // Frame end: commit a complete write or flag a bad length.
      if (state_q != S_IDLE && ncs_rise) begin
         state_d = S_IDLE;
         if (cnt_q == CNT_W'(FRAME)) begin
            if (rx_q[FRAME-1]) begin
               for (int unsigned i = 0; i < NUM_REGS; i++) begin
                  if (addr_q == ADDR_W'(i)) begin
                     regs_d[i*DATA_W +: DATA_W] = rx_q[DATA_W-1:0];
                     wr_strobe_d                = 1'b1;
                     wr_addr_d                  = addr_q;
                  end
               end
            end
         end else if (cnt_q != '0) begin
            frame_err_d = 1'b1;
         end
      end

      if (state_d == S_DATA) begin
         cipo_oe_d = ~rw_d;
      end else begin
         cipo_d    = 1'b0;
         cipo_oe_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sclk_sync_q <= '0;
         ncs_sync_q  <= '0;
         copi_sync_q <= '0;
         cnt_q       <= '0;
         rx_q        <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         tx_q        <= '0;
         cipo_q      <= 1'b0;
         cipo_oe_q   <= 1'b0;
         regs_q      <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         ncs_sync_q  <= ncs_sync_d;
         copi_sync_q <= copi_sync_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         tx_q        <= tx_d;
         cipo_q      <= cipo_d;
         cipo_oe_q   <= cipo_oe_d;
         regs_q      <= regs_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.CIPO      = cipo_q;
   assign bus.cipo_oe   = cipo_oe_q;
   assign bus.regs_out  = regs_q;
   assign bus.wr_strobe = wr_strobe_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: one instance per SPI mode, directed frames,
// write/readback scoreboard and register-file reference model.
module tb_spi_regfile_periph;
   localparam int unsigned NUM_REGS = 5;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned ADDR_W   = 7;
   localparam int unsigned HALF     = 50;

   typedef struct packed {
      logic [1:0] mode;
      logic [6:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [3:0] sclk = 4'b1100;
   logic [3:0] ncs  = 4'hF;
   logic [3:0] copi = 4'h0;
   logic [3:0] cipo, oe, strobe, ferr;
   logic [39:0] regs_mon  [4];
   logic [6:0]  waddr_mon [4];

   int          checks = 0;
   int          errors = 0;
   int          ferr_cnt [4] = '{default: 0};
   wr_t         exp_q[$];
   wr_t         obs_q[$];
   wr_t         mon_w;
   logic [7:0]  rd_exp_q[$];
   logic [39:0] model      [4];
   logic [6:0]  last_waddr [4];

   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_mode
      spi_regfile_periph_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
      assign bus.SCLK     = sclk[m];
      assign bus.nCS      = ncs[m];
      assign bus.COPI     = copi[m];
      assign cipo[m]      = bus.CIPO;
      assign oe[m]        = bus.cipo_oe;
      assign strobe[m]    = bus.wr_strobe;
      assign ferr[m]      = bus.frame_err;
      assign regs_mon[m]  = bus.regs_out;
      assign waddr_mon[m] = bus.wr_addr;
      spi_regfile_periph #(
         .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
         .CPOL(m / 2), .CPHA(m % 2)
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   // Observed side of the scoreboard: every committed write and every frame error.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (ferr[k]) ferr_cnt[k]++;
         if (strobe[k]) begin
            mon_w.mode = 2'(k);
            mon_w.addr = waddr_mon[k];
            mon_w.data = 8'hxx;
            if (waddr_mon[k] < 7'd5) mon_w.data = regs_mon[k][int'(waddr_mon[k])*8 +: 8];
            obs_q.push_back(mon_w);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Controller model: MSB-first frame of nbits, optional 1-clk reset pulse before bit rst_bit.
   task automatic spi_frame(input int m, input int nbits, input logic [31:0] word,
                            input int rst_bit, output logic [31:0] miso, output logic [31:0] oe_seen);
      logic cpol, cpha;
      cpol    = (m >= 2);
      cpha    = (m % 2 == 1);
      miso    = '0;
      oe_seen = '0;
      ncs[m]  = 1'b0;
      #(HALF);
      for (int b = 0; b < nbits; b++) begin
         if (b == rst_bit) begin
            @(negedge clk) rst = 1'b1;
            @(negedge clk) rst = 1'b0;
         end
         if (cpha) sclk[m] = ~cpol;
         copi[m] = word[nbits-1-b];
         #(HALF);
         miso    = {miso[30:0], cipo[m]};
         oe_seen = {oe_seen[30:0], oe[m]};
         sclk[m] = cpha ? cpol : ~cpol;
         #(HALF);
         if (!cpha) sclk[m] = cpol;
      end
      #(HALF);
      ncs[m] = 1'b1;
   endtask

   task automatic settle_and_check(input int m, input string tag, input int f0, input int exp_ferr);
      repeat (6) @(posedge clk);
      #1;
      chk({tag, "_regs"}, 64'(regs_mon[m]), 64'(model[m]));
      chk({tag, "_ferr"}, 64'(ferr_cnt[m] - f0), 64'(exp_ferr));
      chk({tag, "_strobes"}, 64'(obs_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0)
         chk({tag, "_sb"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
      exp_q.delete();
      obs_q.delete();
      chk({tag, "_waddr"}, 64'(waddr_mon[m]), 64'(last_waddr[m]));
      chk({tag, "_idle"}, 64'({cipo[m], oe[m]}), 64'(0));
   endtask

   task automatic do_write(input int m, input logic [6:0] addr, input logic [7:0] data, input string tag);
      logic [31:0] mi, oe_s;
      wr_t         e;
      int          f0;
      f0 = ferr_cnt[m];
      if (addr < 7'd5) begin
         e.mode = 2'(m);
         e.addr = addr;
         e.data = data;
         exp_q.push_back(e);
         model[m][int'(addr)*8 +: 8] = data;
         last_waddr[m] = addr;
      end
      spi_frame(m, 16, {16'h0, 1'b1, addr, data}, -1, mi, oe_s);
      chk({tag, "_oe"}, 64'(oe_s), 64'(0));
      settle_and_check(m, tag, f0, 0);
   endtask

   task automatic do_read(input int m, input logic [6:0] addr, input string tag);
      logic [31:0] mi, oe_s;
      logic [7:0]  e;
      int          f0;
      f0 = ferr_cnt[m];
      if (addr < 7'd5) rd_exp_q.push_back(model[m][int'(addr)*8 +: 8]);
      else             rd_exp_q.push_back(8'h00);
      spi_frame(m, 16, {16'h0, 1'b0, addr, 8'hA5}, -1, mi, oe_s);
      e = rd_exp_q.pop_front();
      chk({tag, "_cipo"}, 64'(mi[15:0]), 64'({8'h00, e}));
      chk({tag, "_oe"}, 64'(oe_s[15:0]), 64'(16'h00FF));
      settle_and_check(m, tag, f0, 0);
   endtask

   task automatic do_bad(input int m, input int nbits, input logic [31:0] word, input string tag);
      logic [31:0] mi, oe_s;
      int          f0;
      f0 = ferr_cnt[m];
      spi_frame(m, nbits, word, -1, mi, oe_s);
      settle_and_check(m, tag, f0, 1);
   endtask

   initial begin
      logic [31:0] mi, oe_s;
      int          f0;
      for (int k = 0; k < 4; k++) begin
         model[k]      = '0;
         last_waddr[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("m%0d_rst_regs", k), 64'(regs_mon[k]), 64'(0));
         chk($sformatf("m%0d_rst_cipo", k), 64'(cipo[k]), 64'(0));
         chk($sformatf("m%0d_rst_oe", k), 64'(oe[k]), 64'(0));
         chk($sformatf("m%0d_rst_strobe", k), 64'(strobe[k]), 64'(0));
         chk($sformatf("m%0d_rst_ferr", k), 64'(ferr[k]), 64'(0));
         chk($sformatf("m%0d_rst_waddr", k), 64'(waddr_mon[k]), 64'(0));
      end
      @(negedge clk) rst = 1'b0;
      repeat (4) @(posedge clk);

      for (int m = 0; m < 4; m++) begin
         do_write(m, 7'd4, 8'h55, $sformatf("m%0d_wr4", m));
         do_write(m, 7'd1, 8'hA5, $sformatf("m%0d_wr1", m));
         do_read(m, 7'd1, $sformatf("m%0d_rd1", m));
         do_bad(m, 12, 32'h0000_0F0F, $sformatf("m%0d_short", m));
         do_bad(m, 17, 32'h0001_0155, $sformatf("m%0d_long", m));
         do_write(m, 7'h10, 8'h3C, $sformatf("m%0d_wr_oob", m));
         do_read(m, 7'h10, $sformatf("m%0d_rd_oob", m));
         do_read(m, 7'd4, $sformatf("m%0d_rd4", m));
      end

      // Reset pulse in the middle of a mode-0 write to addr 2 clears every instance.
      f0 = ferr_cnt[0];
      spi_frame(0, 16, {16'h0, 1'b1, 7'd2, 8'hF0}, 9, mi, oe_s);
      for (int k = 0; k < 4; k++) begin
         model[k]      = '0;
         last_waddr[k] = '0;
      end
      settle_and_check(0, "m0_rst_abort", f0, 0);
      for (int k = 1; k < 4; k++)
         chk($sformatf("m%0d_rst_abort_regs", k), 64'(regs_mon[k]), 64'(0));
      do_write(0, 7'd2, 8'hF0, "m0_after_rst");
      do_read(0, 7'd2, "m0_after_rst_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_regfile_periph.md
Name: spi_regfile_periph

Overview:
- Parametrised successor of the team's SPI write-only register peripheral.
- Adds configurable register count, data width and address width, SPI modes 0–3, register readback on CIPO, strict frame-length checking and a write strobe.
- Sits between the chip's SPI pins and the output-enable/PWM control logic, running in the system clk domain with oversampled SPI inputs.

Parameters:
- NUM_REGS, 5, number of implemented registers, addresses 0..NUM_REGS-1.
- DATA_W, 8, bits per register and per frame data field.
- ADDR_W, 7, address field width; NUM_REGS must be ≤ 2**ADDR_W.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- clk  in  1  system clock; SCLK frequency must be ≤ clk/6.
- rst  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock, asynchronous.
- nCS  in  1  SPI chip select, active low, asynchronous.
- COPI  in  1  controller-out data, asynchronous.
- CIPO  out  1  peripheral-out data.
- cipo_oe  out  1  CIPO output enable; high only during the data phase of a read frame.
- regs_out  out  NUM_REGS*DATA_W  flattened register contents; reg i is at [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-clk pulse when a write commits.
- wr_addr  out  ADDR_W  address of the last committed write.
- frame_err  out  1  one-clk pulse when a frame ends with the wrong bit count.

Behaviour:
- Sync: SCLK, nCS and COPI each pass through a 2-flop synchroniser. Edges are detected on the synchronised signals against a one-cycle-delayed copy. Leading/trailing edge is derived from CPOL. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- Frame format: FRAME = 1+ADDR_W+DATA_W bits, MSB first. Field order is R/W bit (1 = write, 0 = read), address, data.
- Bit counter: cleared while synchronised nCS is high. Increments on each sample edge while nCS is low and saturates at FRAME+1 (overrun marker). Sample edges after FRAME bits do not shift.
- State machine:
  - IDLE: nCS high.
  - ADDR: sampling the R/W bit and address.
  - DATA: sampling or driving the data field.
  - DONE: FRAME bits received, waiting for nCS to rise.
  - Transitions: IDLE→ADDR on nCS falling. ADDR→DATA after 1+ADDR_W sample edges. DATA→DONE after FRAME edges. Any state→IDLE on nCS rising.
- Read frames:
  - On entering DATA, load a DATA_W shift register with reg[addr], or zero if addr ≥ NUM_REGS.
  - cipo_oe is asserted for the whole DATA state.
  - CPHA=0: the data MSB is driven within 1 clk of the sample edge of the last address bit, so it is valid before the first data sample edge. Subsequent bits advance on shift edges.
  - CPHA=1: each data bit is driven on the shift (leading) edge of its bit period.
  - Outside DATA: CIPO=0 and cipo_oe=0.
  - Read frames never modify registers.
- Write commit: on synchronised nCS rising with bit count == FRAME and R/W=1:
  - If addr < NUM_REGS, reg[addr] ← data on the next clk edge, wr_strobe pulses for 1 clk, and wr_addr ← addr.
  - If addr ≥ NUM_REGS, the write is silently dropped: no strobe, no error.
- Length check: on nCS rising, frame_err pulses for 1 clk if the bit count is nonzero and ≠ FRAME (short or overrun). Nothing commits in that case. nCS toggling with zero bits gives no error.
- Latency: pin nCS rising → register update ≤ 4 clk.
- Reset: all registers 0, regs_out=0, CIPO=0, cipo_oe=0, wr_strobe=0, frame_err=0, wr_addr=0, state=IDLE, counters and synchronisers cleared.
  - Reset asserted mid-frame aborts the frame.
  - After reset releases with nCS already low, no frame is accepted until nCS goes high then low again. The FSM stays IDLE until it sees an nCS fall.
- Back-to-back frames: consecutive frames separated by nCS high for ≥ 3 clk must both be processed correctly.

Test Plan:
- Defaults, mode 0: write frame 0x8455 (addr 4, data 0x55) → regs_out[39:32]=0x55, one wr_strobe, wr_addr=4, other regs unchanged.
- Write 0x01A5 with R/W=0 (read of addr 1), after a prior write of 0xA5 to addr 1 → CIPO shifts out 1010_0101 with cipo_oe high only during bits 8–15; registers unchanged.
- Frame of 12 bits, then of 17 bits, each with write bit set → frame_err pulses once per frame; no register changes; no wr_strobe.
- Write to addr 0x10 (≥ NUM_REGS) → no strobe, no frame_err, regs unchanged. Read of addr 0x10 → CIPO returns 0x00.
- Repeat the first two scenarios with CPOL/CPHA = (0,1), (1,0) and (1,1) → identical register and readback results.
- Assert rst for 1 clk at bit 9 of a write to addr 2 → frame dropped, all regs 0. The next full frame writing 0xF0 to addr 2 commits correctly.
